// File: rtl/regfile_pkg.sv
// Shared sizes and index/data types for the general-purpose register file.
package regfile_pkg;
  localparam int DATA_SIZE_DEF = 32;
  localparam int ADDR_SIZE_DEF = 5;

  typedef logic [ADDR_SIZE_DEF-1:0] reg_idx_t;
  typedef logic [DATA_SIZE_DEF-1:0] reg_data_t;

  localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Read/write/scoreboard bus between the issue/writeback stages and the register file.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) ();
  logic [ADDR_SIZE-1:0] rs1_addr;
  logic                 rs1_rd_en;
  logic [DATA_SIZE-1:0] rs1_data;
  logic [ADDR_SIZE-1:0] rs2_addr;
  logic                 rs2_rd_en;
  logic [DATA_SIZE-1:0] rs2_data;
  logic                 wa_en;
  logic [ADDR_SIZE-1:0] wa_addr;
  logic [DATA_SIZE-1:0] wa_data;
  logic                 wb_en;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic [DATA_SIZE-1:0] wb_data;
  logic                 pend_set;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 stall;
  logic [ADDR_SIZE:0]   pend_cnt;

  modport master (
    output rs1_addr, rs1_rd_en, rs2_addr, rs2_rd_en,
    output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    output pend_set, pend_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pend_cnt
  );

  modport slave (
    input  rs1_addr, rs1_rd_en, rs2_addr, rs2_rd_en,
    input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    input  pend_set, pend_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-load scoreboard: one bit per register, exact popcount, per-port busy flags.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int REG_NUM   = 2**ADDR_SIZE_DEF,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pend_set_i,
  input  logic [ADDR_SIZE-1:0] pend_addr_i,
  input  logic                 wb_en_i,
  input  logic [ADDR_SIZE-1:0] wb_addr_i,
  input  logic [ADDR_SIZE-1:0] rs1_addr_i,
  input  logic [ADDR_SIZE-1:0] rs2_addr_i,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o,
  output logic [ADDR_SIZE:0]   pend_cnt_o
);
  localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE+1)'(1);
  localparam logic               BYP_EN  = (BYPASS != 0);

  logic [REG_NUM-1:0] pend_q, pend_d;
  logic [ADDR_SIZE:0] cnt_q, cnt_d;
  logic               set_ok, set_new, clr_hit;

  // A set and clear of the same index resolves to set, so the clear is
  // suppressed before counting; that keeps cnt equal to the popcount.
  always_comb begin
    set_ok  = pend_set_i && !((ZERO_REG != 0) && (pend_addr_i == '0));
    set_new = set_ok && !pend_q[pend_addr_i];
    clr_hit = wb_en_i && pend_q[wb_addr_i] && !(set_ok && (pend_addr_i == wb_addr_i));
    pend_d  = pend_q;
    if (clr_hit) pend_d[wb_addr_i] = 1'b0;
    if (set_ok)  pend_d[pend_addr_i] = 1'b1;
    cnt_d = cnt_q;
    if (set_new && !clr_hit)      cnt_d = cnt_q + CNT_ONE;
    else if (!set_new && clr_hit) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs1_busy_o = pend_q[rs1_addr_i] && !(BYP_EN && wb_en_i && (wb_addr_i == rs1_addr_i));
    rs2_busy_o = pend_q[rs2_addr_i] && !(BYP_EN && wb_en_i && (wb_addr_i == rs2_addr_i));
    pend_cnt_o = cnt_q;
  end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/two-write register file with integrated load scoreboard and optional bypass.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int REG_NUM   = 2**ADDR_SIZE_DEF,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam logic ZR_EN  = (ZERO_REG != 0);
  localparam logic BYP_EN = (BYPASS != 0);

  logic [DATA_SIZE-1:0] mreg_q [REG_NUM];
  logic                 wa_ok, wb_ok;
  logic                 sb_busy1, sb_busy2;

  // Port A wins a same-index collision; port B's data is dropped but its
  // pending-bit clear still happens in the scoreboard.
  always_comb begin
    wa_ok = bus.wa_en && !(ZR_EN && (bus.wa_addr == '0));
    wb_ok = bus.wb_en && !(ZR_EN && (bus.wb_addr == '0))
            && !(wa_ok && (bus.wa_addr == bus.wb_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) mreg_q[i] <= '0;
    end else begin
      if (wa_ok) mreg_q[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) mreg_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  function automatic logic [DATA_SIZE-1:0] rd_mux(
    input logic                 rd_en,
    input logic [ADDR_SIZE-1:0] addr,
    input logic [DATA_SIZE-1:0] arr_val,
    input logic                 wa_en,
    input logic [ADDR_SIZE-1:0] wa_addr,
    input logic [DATA_SIZE-1:0] wa_data,
    input logic                 wb_en,
    input logic [ADDR_SIZE-1:0] wb_addr,
    input logic [DATA_SIZE-1:0] wb_data
  );
    if (!rd_en)                                   return '0;
    if (ZR_EN && (addr == '0))                    return '0;
    if (BYP_EN && wa_en && (wa_addr == addr))     return wa_data;
    if (BYP_EN && wb_en && (wb_addr == addr))     return wb_data;
    return arr_val;
  endfunction

  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rs1_busy = 1'b0;
    bus.rs2_busy = 1'b0;
    bus.stall    = 1'b0;
    if (!rst) begin
      bus.rs1_data = rd_mux(bus.rs1_rd_en, bus.rs1_addr, mreg_q[bus.rs1_addr],
                            bus.wa_en, bus.wa_addr, bus.wa_data,
                            bus.wb_en, bus.wb_addr, bus.wb_data);
      bus.rs2_data = rd_mux(bus.rs2_rd_en, bus.rs2_addr, mreg_q[bus.rs2_addr],
                            bus.wa_en, bus.wa_addr, bus.wa_data,
                            bus.wb_en, bus.wb_addr, bus.wb_data);
      bus.rs1_busy = sb_busy1;
      bus.rs2_busy = sb_busy2;
      bus.stall    = (bus.rs1_rd_en && sb_busy1) || (bus.rs2_rd_en && sb_busy2);
    end
  end

  reg_scoreboard #(
    .ADDR_SIZE (ADDR_SIZE),
    .REG_NUM   (REG_NUM),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .pend_set_i  (bus.pend_set),
    .pend_addr_i (bus.pend_addr),
    .wb_en_i     (bus.wb_en),
    .wb_addr_i   (bus.wb_addr),
    .rs1_addr_i  (bus.rs1_addr),
    .rs2_addr_i  (bus.rs2_addr),
    .rs1_busy_o  (sb_busy1),
    .rs2_busy_o  (sb_busy2),
    .pend_cnt_o  (bus.pend_cnt)
  );
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the CPU core: two read ports and two write ports.
  - Write port A: ALU/EX writeback.
  - Write port B: late load/memory writeback.
- Integrated pending-write scoreboard: a destination register is marked busy when a load issues and released when its data returns on port B.
- Optional same-cycle write-to-read bypass.
- Drives a combinational stall to the issue/decode stage. Replaces the fixed 32x32 single-write register file.

Parameters:
- DATA_SIZE, 32, register width in bits
- ADDR_SIZE, 5, register index width
- REG_NUM, 32, number of registers (must equal 2**ADDR_SIZE)
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and pend_set to 0 ignored)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy masked

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs1_addr  input  ADDR_SIZE  read port 1 index
- rs1_rd_en  input  1  read port 1 valid
- rs1_data  output  DATA_SIZE  read port 1 data (combinational)
- rs2_addr  input  ADDR_SIZE  read port 2 index
- rs2_rd_en  input  1  read port 2 valid
- rs2_data  output  DATA_SIZE  read port 2 data (combinational)
- wa_en  input  1  write port A enable
- wa_addr  input  ADDR_SIZE  write port A index
- wa_data  input  DATA_SIZE  write port A data
- wb_en  input  1  write port B enable (load return)
- wb_addr  input  ADDR_SIZE  write port B index
- wb_data  input  DATA_SIZE  write port B data
- pend_set  input  1  load issued; mark pend_addr pending
- pend_addr  input  ADDR_SIZE  destination of issued load
- rs1_busy  output  1  rs1 source pending
- rs2_busy  output  1  rs2 source pending
- stall  output  1  (rs1_rd_en & rs1_busy) | (rs2_rd_en & rs2_busy)
- pend_cnt  output  ADDR_SIZE+1  number of registers currently pending

Behaviour:

Reset
- rst high at a rising edge: all REG_NUM registers <= 0, all pending bits <= 0, pend_cnt <= 0.
- While rst is high, rs1_data, rs2_data, rs1_busy, rs2_busy and stall are forced to 0.
- Reset mid-operation discards all pending state; a later wb_en for a discarded load is an ordinary write.

Writes (one-cycle latency)
- Data is visible in the register array from the cycle after the write edge.
- Index 0 is ignored when ZERO_REG=1.
- wa_en and wb_en to the same index in the same cycle: port A data is stored, port B data is dropped. Port B still clears the pending bit.
- Different indices: both writes occur.

Reads (combinational)
- rd_en low: data output = 0.
- Otherwise data = mreg[addr]. Index 0 reads 0 when ZERO_REG=1.
- BYPASS=1: a same-cycle write to the read index is forwarded, with port A having priority over port B, then the array value.
- BYPASS=0: reads return array contents only (write-then-read takes 2 cycles).

Scoreboard
- pend_set sets pending[pend_addr] at the edge (ignored for index 0 when ZERO_REG=1).
- wb_en clears pending[wb_addr].
- Same index set and cleared in one cycle: set wins (new load re-marks it).
- pend_set to an already-pending index: no change; the count is not double-incremented.
- wa writes do not touch pending bits.
- rsX_busy = pending[rsX_addr] & ~(BYPASS & wb_en & wb_addr==rsX_addr).
- pend_cnt tracks the popcount of pending bits exactly: +1, -1, 0 or net 0 when a set and a clear of different indices occur in the same cycle. Range is 0..REG_NUM; it cannot wrap.

Decomposition:
- Shared package regfile_pkg:
  - DATA_SIZE and ADDR_SIZE defaults
  - typedef reg_idx_t (logic[ADDR_SIZE-1:0])
  - typedef reg_data_t
  - constant ZERO_IDX
- One natural sub-module, reg_scoreboard: pending bit vector, pend_cnt, busy generation.
- The array, write arbitration and bypass muxing stay in reg_file_sb.

Test Plan:
- Reset, then write wa_en idx 5 = 0xDEADBEEF; next cycle read rs1=5 -> rs1_data=0xDEADBEEF. Assert rst one cycle -> rs1_data=0 and the register reads 0 after reset.
- Write idx 0 = 0x1234 via both ports, read rs1=0 -> 0 (ZERO_REG=1). pend_set idx 0 -> pend_cnt stays 0.
- BYPASS=1: wa idx 7 = 0xA5A5A5A5 with rs2=7 same cycle -> rs2_data=0xA5A5A5A5 that cycle. With BYPASS=0 -> old value (0) that cycle, 0xA5A5A5A5 next cycle.
- pend_set idx 10, then read rs1=10 with rs1_rd_en -> rs1_busy=1, stall=1, pend_cnt=1. wb_en idx 10 = 0x55 -> same-cycle rs1_data=0x55, busy=0, stall=0 (BYPASS=1); next cycle pend_cnt=0.
- Same cycle: wa idx 3 = 0x11, wb idx 3 = 0x22, pend_set idx 3 with pending[3] previously set -> reg 3 = 0x11, pending[3] stays 1, pend_cnt unchanged.
- Same cycle: pend_set idx 4 and wb_en idx 9 with pending[9]=1 -> pending[4]=1, pending[9]=0, pend_cnt unchanged. Set all 31 non-zero indices -> pend_cnt=31, no wrap.
